// File: rtl/tmr_cnt_ctrl.sv
// Timer counter control: pclk prescaler, clock-select tick generation,
// load/run/stop sequencing and sticky overflow/underflow flags.
module tmr_cnt_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             pclk,
  input  logic             presetn,
  input  logic [1:0]       tcr_cks,
  input  logic             tcr_en,
  input  logic             tcr_dn,
  input  logic             tcr_load,
  input  logic [WIDTH-1:0] tdr,
  input  logic             clr_ovf,
  input  logic             clr_udf,
  output logic             clk_cnt,
  output logic             pos_clk_int,
  output logic             tick,
  output logic [WIDTH-1:0] cnt,
  output logic             ovf_flag,
  output logic             udf_flag,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_div;
  logic             r_sel_prev;
  logic [1:0]       r_cks_q;
  logic             r_load_q;
  logic [WIDTH-1:0] r_cnt;
  logic             r_ovf;
  logic             r_udf;

  logic             w_clk_cnt;
  logic             w_cks_same;
  logic             w_pos;
  logic             w_tick;
  logic             w_load_rise;
  logic             w_cnt_en;
  logic             w_wrap_up;
  logic             w_wrap_dn;

  assign w_clk_cnt   = r_div[tcr_cks];
  // A select change swaps mux inputs; the resulting edge is not real.
  assign w_cks_same  = (tcr_cks == r_cks_q);
  assign w_pos       = w_clk_cnt & ~r_sel_prev & w_cks_same;
  assign w_tick      = w_pos & (r_state == S_RUN);
  assign w_load_rise = tcr_load & ~r_load_q;
  assign w_cnt_en    = w_tick & ~w_load_rise;
  assign w_wrap_up   = w_cnt_en & ~tcr_dn & (r_cnt == '1);
  assign w_wrap_dn   = w_cnt_en & tcr_dn & (r_cnt == '0);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_div      <= '0;
      r_sel_prev <= 1'b0;
      r_cks_q    <= '0;
      r_load_q   <= 1'b0;
    end else begin
      r_div      <= r_div + 4'd1;
      r_sel_prev <= w_clk_cnt;
      r_cks_q    <= tcr_cks;
      r_load_q   <= tcr_load;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_load_rise) begin
          w_next = S_LOAD;
        end else if (tcr_en) begin
          w_next = S_RUN;
        end
      end
      S_LOAD: begin
        w_next = tcr_en ? S_RUN : S_IDLE;
      end
      S_RUN: begin
        if (w_load_rise) begin
          w_next = S_LOAD;
        end else if (!tcr_en) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_cnt <= '0;
    end else if (r_state == S_LOAD) begin
      r_cnt <= tdr;
    end else if (w_cnt_en) begin
      if (tcr_dn) begin
        r_cnt <= r_cnt - 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Set wins over a coincident clear.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (w_wrap_up) begin
        r_ovf <= 1'b1;
      end else if (clr_ovf) begin
        r_ovf <= 1'b0;
      end
      if (w_wrap_dn) begin
        r_udf <= 1'b1;
      end else if (clr_udf) begin
        r_udf <= 1'b0;
      end
    end
  end

  assign clk_cnt     = w_clk_cnt;
  assign pos_clk_int = w_pos;
  assign tick        = w_tick;
  assign cnt         = r_cnt;
  assign ovf_flag    = r_ovf;
  assign udf_flag    = r_udf;
  assign busy        = (r_state == S_LOAD);

endmodule

// File: tb/tb_tmr_cnt_ctrl.sv
// Directed self-checking bench for tmr_cnt_ctrl.
// Inputs change and outputs are sampled on the falling pclk edge.
module tb_tmr_cnt_ctrl;

  localparam int WIDTH = 8;
  localparam int PER   = 10;

  logic             pclk = 1'b0;
  logic             presetn;
  logic [1:0]       tcr_cks;
  logic             tcr_en;
  logic             tcr_dn;
  logic             tcr_load;
  logic [WIDTH-1:0] tdr;
  logic             clr_ovf;
  logic             clr_udf;
  logic             clk_cnt;
  logic             pos_clk_int;
  logic             tick;
  logic [WIDTH-1:0] cnt;
  logic             ovf_flag;
  logic             udf_flag;
  logic             busy;

  int n_chk  = 0;
  int n_fail = 0;

  always #(PER/2) pclk = ~pclk;

  tmr_cnt_ctrl #(.WIDTH(WIDTH)) dut (
    .pclk       (pclk),
    .presetn    (presetn),
    .tcr_cks    (tcr_cks),
    .tcr_en     (tcr_en),
    .tcr_dn     (tcr_dn),
    .tcr_load   (tcr_load),
    .tdr        (tdr),
    .clr_ovf    (clr_ovf),
    .clr_udf    (clr_udf),
    .clk_cnt    (clk_cnt),
    .pos_clk_int(pos_clk_int),
    .tick       (tick),
    .cnt        (cnt),
    .ovf_flag   (ovf_flag),
    .udf_flag   (udf_flag),
    .busy       (busy)
  );

  task automatic test_reset;
    presetn  = 1'b0;
    tcr_cks  = 2'd0;
    tcr_en   = 1'b0;
    tcr_dn   = 1'b0;
    tcr_load = 1'b0;
    tdr      = '0;
    clr_ovf  = 1'b0;
    clr_udf  = 1'b0;
    repeat (3) @(negedge pclk);
    n_chk++;
    if ({clk_cnt, pos_clk_int, tick, ovf_flag, udf_flag, busy} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_bits got=%b want=000000",
               {clk_cnt, pos_clk_int, tick, ovf_flag, udf_flag, busy});
    end
    n_chk++;
    if (cnt !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_cnt got=%h want=00", cnt);
    end
    presetn = 1'b1;
    @(negedge pclk);
  endtask

  task automatic test_period;
    for (int c = 0; c < 4; c++) begin
      int  nt;
      int  np;
      int  exp_n;
      int  per;
      time t0;
      time t1;
      tcr_cks = c[1:0];
      tcr_en  = 1'b1;
      repeat (20) @(negedge pclk);
      nt    = 0;
      np    = 0;
      t0    = 0;
      t1    = 0;
      exp_n = 320 >> (c + 1);
      per   = PER << (c + 1);
      for (int i = 0; i < 320; i++) begin
        @(negedge pclk);
        if (tick === 1'b1) nt++;
        if (pos_clk_int === 1'b1) begin
          if (np == 0) t0 = $time;
          t1 = $time;
          np++;
        end
      end
      n_chk++;
      if (nt != exp_n) begin
        n_fail++;
        $display("FAIL tick_count cks=%0d got=%0d want=%0d", c, nt, exp_n);
      end
      n_chk++;
      if (np != exp_n || (t1 - t0) != time'((np - 1) * per)) begin
        n_fail++;
        $display("FAIL clk_period cks=%0d edges=%0d span=%0t want_edges=%0d want_span=%0d",
                 c, np, t1 - t0, exp_n, (exp_n - 1) * per);
      end
    end
  endtask

  task automatic test_switch;
    bit found;
    tcr_cks = 2'd3;
    tcr_en  = 1'b1;
    repeat (4) @(negedge pclk);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (dut.r_div == 4'b0111) found = 1'b1;
      else @(negedge pclk);
    end
    n_chk++;
    if (!found) begin
      n_fail++;
      $display("FAIL switch_sync got=no_div7 want=div7");
    end
    tcr_cks = 2'd0;
    #1;
    n_chk++;
    if (pos_clk_int !== 1'b0 || clk_cnt !== 1'b1) begin
      n_fail++;
      $display("FAIL switch_cycle got pos=%b clk=%b want pos=0 clk=1",
               pos_clk_int, clk_cnt);
    end
    @(negedge pclk);
    n_chk++;
    if (pos_clk_int !== 1'b0) begin
      n_fail++;
      $display("FAIL switch_next got=%b want=0", pos_clk_int);
    end
    @(negedge pclk);
    n_chk++;
    if (pos_clk_int !== 1'b1 || tick !== 1'b1) begin
      n_fail++;
      $display("FAIL switch_first_tick got pos=%b tick=%b want 1 1",
               pos_clk_int, tick);
    end
  endtask

  task automatic test_load_up;
    logic [7:0] exp;
    logic [7:0] prev;
    tcr_en  = 1'b0;
    tcr_cks = 2'd0;
    tcr_dn  = 1'b0;
    tdr     = 8'hFD;
    @(negedge pclk);
    clr_ovf = 1'b1;
    clr_udf = 1'b1;
    @(negedge pclk);
    clr_ovf = 1'b0;
    clr_udf = 1'b0;
    tcr_en  = 1'b1;
    repeat (2) @(negedge pclk);
    tcr_load = 1'b1;
    @(negedge pclk);
    n_chk++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL load_busy got=%b want=1", busy);
    end
    @(negedge pclk);
    n_chk++;
    if (cnt !== 8'hFD || busy !== 1'b0 || ovf_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL load_value got cnt=%h busy=%b ovf=%b want FD 0 0",
               cnt, busy, ovf_flag);
    end
    exp  = 8'hFE;
    prev = cnt;
    for (int i = 0; i < 12 && exp != 8'h01; i++) begin
      @(negedge pclk);
      if (cnt !== prev) begin
        n_chk++;
        if (cnt !== exp || ovf_flag !== (exp == 8'h00)) begin
          n_fail++;
          $display("FAIL up_seq got cnt=%h ovf=%b want cnt=%h ovf=%b",
                   cnt, ovf_flag, exp, exp == 8'h00);
        end
        prev = cnt;
        exp  = exp + 8'h01;
      end
    end
    n_chk++;
    if (exp != 8'h01) begin
      n_fail++;
      $display("FAIL up_timeout got next=%h want=01", exp);
    end
    tcr_load = 1'b0;
    clr_ovf  = 1'b1;
    @(negedge pclk);
    clr_ovf = 1'b0;
    n_chk++;
    if (ovf_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear got=%b want=0", ovf_flag);
    end
  endtask

  task automatic test_udf_clear;
    bit found;
    tcr_dn   = 1'b1;
    tdr      = 8'h00;
    tcr_load = 1'b0;
    @(negedge pclk);
    tcr_load = 1'b1;
    repeat (2) @(negedge pclk);
    n_chk++;
    if (cnt !== 8'h00) begin
      n_fail++;
      $display("FAIL udf_load got=%h want=00", cnt);
    end
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      if (tick === 1'b1) found = 1'b1;
      else @(negedge pclk);
    end
    clr_udf = 1'b1;
    @(negedge pclk);
    clr_udf = 1'b0;
    n_chk++;
    if (!found || cnt !== 8'hFF || udf_flag !== 1'b1) begin
      n_fail++;
      $display("FAIL udf_collision got tick=%b cnt=%h udf=%b want 1 FF 1",
               found, cnt, udf_flag);
    end
    @(negedge pclk);
    n_chk++;
    if (udf_flag !== 1'b1 || ovf_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL udf_sticky got udf=%b ovf=%b want 1 0", udf_flag, ovf_flag);
    end
    tcr_load = 1'b0;
  endtask

  task automatic test_load_vs_tick;
    logic [7:0] c0;
    bit         found;
    tcr_dn   = 1'b0;
    tcr_cks  = 2'd0;
    tcr_en   = 1'b1;
    tcr_load = 1'b0;
    repeat (2) @(negedge pclk);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      if (tick === 1'b1) found = 1'b1;
      else @(negedge pclk);
    end
    c0       = cnt;
    tdr      = 8'h5A;
    tcr_load = 1'b1;
    @(negedge pclk);
    n_chk++;
    if (!found || cnt !== c0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL lvt_drop got tick=%b cnt=%h busy=%b want 1 %h 1",
               found, cnt, busy, c0);
    end
    @(negedge pclk);
    n_chk++;
    if (cnt !== 8'h5A || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL lvt_load got cnt=%h busy=%b want 5A 0", cnt, busy);
    end
    tcr_load = 1'b0;
  endtask

  task automatic test_stop_reset;
    bit found;
    int bad;
    tdr = 8'h0E;
    @(negedge pclk);
    tcr_load = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge pclk);
      if (cnt === 8'h10) found = 1'b1;
    end
    tcr_en   = 1'b0;
    tcr_load = 1'b0;
    bad = 0;
    repeat (100) begin
      @(negedge pclk);
      if (cnt !== 8'h10 || (tick !== 1'b0 && !found)) bad++;
      else if (tick !== 1'b0) bad++;
    end
    n_chk++;
    if (!found || bad != 0) begin
      n_fail++;
      $display("FAIL stop_hold got reached=%b bad_cycles=%0d cnt=%h want 1 0 10",
               found, bad, cnt);
    end
    tcr_en  = 1'b1;
    tcr_cks = 2'd1;
    repeat (7) @(negedge pclk);
    presetn = 1'b0;
    #1;
    n_chk++;
    if ({clk_cnt, pos_clk_int, tick, ovf_flag, udf_flag, busy} !== 6'b0 ||
        cnt !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset got bits=%b cnt=%h want 000000 00",
               {clk_cnt, pos_clk_int, tick, ovf_flag, udf_flag, busy}, cnt);
    end
    @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);
  endtask

  initial begin
    test_reset;
    test_period;
    test_switch;
    test_load_up;
    test_udf_clear;
    test_load_vs_tick;
    test_stop_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
